// File: rtl/memory_game_ctrl.sv
// rtl/memory_game_ctrl.sv - multi-round memorization game sequencer
// Shows a latched random target, collects keypad digits, scores the round and tracks level/lives.
module memory_game_ctrl #(
    parameter int MAX_DIGITS   = 8,
    parameter int START_DIGITS = 4,
    parameter int LIVES        = 3,
    parameter int SHOW_TICKS   = 6,
    parameter int ENTER_TICKS  = 20,
    parameter int RESULT_TICKS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick_en,
    input  logic                    start,
    input  logic [4*MAX_DIGITS-1:0] rand_val,
    input  logic                    key_valid,
    input  logic [3:0]              key_val,
    output logic [2:0]              phase,
    output logic [4*MAX_DIGITS-1:0] target,
    output logic [4*MAX_DIGITS-1:0] entry,
    output logic [3:0]              entry_cnt,
    output logic [3:0]              cur_len,
    output logic [2:0]              lives_left,
    output logic [7:0]              score,
    output logic                    pass,
    output logic                    fail
);
    localparam int W = 4 * MAX_DIGITS;
    localparam logic [7:0] SHOW_T   = 8'(SHOW_TICKS);
    localparam logic [7:0] ENTER_T  = 8'(ENTER_TICKS);
    localparam logic [7:0] RESULT_T = 8'(RESULT_TICKS);
    localparam logic [3:0] START_L  = 4'(START_DIGITS);
    localparam logic [3:0] MAX_L    = 4'(MAX_DIGITS);
    localparam logic [2:0] LIVES_L  = 3'(LIVES);

    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_SHOW   = 3'd1,
        PH_ENTER  = 3'd2,
        PH_RESULT = 3'd3,
        PH_OVER   = 3'd4
    } phase_t;

    phase_t       r_phase, w_phase_nxt;
    logic [W-1:0] r_target, w_target_nxt;
    logic [W-1:0] r_entry, w_entry_nxt;
    logic [3:0]   r_entry_cnt, w_entry_cnt_nxt;
    logic [3:0]   r_cur_len, w_cur_len_nxt;
    logic [2:0]   r_lives, w_lives_nxt;
    logic [7:0]   r_score, w_score_nxt;
    logic [7:0]   r_timer, w_timer_nxt;
    logic         r_pass, w_pass_nxt;
    logic         r_fail, w_fail_nxt;
    logic         r_res_pass, w_res_pass_nxt;

    logic         w_key_digit;
    logic [W-1:0] w_entry_shift;
    logic [3:0]   w_cnt_inc;
    logic [3:0]   w_len_up;

    function automatic logic [W-1:0] mask_digits(input logic [W-1:0] v, input logic [3:0] len);
        logic [W-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < int'(len)) m[4*i +: 4] = v[4*i +: 4];
        end
        return m;
    endfunction

    assign w_key_digit   = key_valid && (key_val <= 4'd9);
    assign w_entry_shift = {r_entry[W-5:0], key_val};
    assign w_cnt_inc     = r_entry_cnt + 4'd1;
    assign w_len_up      = (r_cur_len < MAX_L) ? r_cur_len + 4'd1 : r_cur_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase     <= PH_IDLE;
            r_target    <= '0;
            r_entry     <= '0;
            r_entry_cnt <= '0;
            r_cur_len   <= START_L;
            r_lives     <= LIVES_L;
            r_score     <= '0;
            r_timer     <= '0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_res_pass  <= 1'b0;
        end else begin
            r_phase     <= w_phase_nxt;
            r_target    <= w_target_nxt;
            r_entry     <= w_entry_nxt;
            r_entry_cnt <= w_entry_cnt_nxt;
            r_cur_len   <= w_cur_len_nxt;
            r_lives     <= w_lives_nxt;
            r_score     <= w_score_nxt;
            r_timer     <= w_timer_nxt;
            r_pass      <= w_pass_nxt;
            r_fail      <= w_fail_nxt;
            r_res_pass  <= w_res_pass_nxt;
        end
    end

    always_comb begin
        w_phase_nxt     = r_phase;
        w_target_nxt    = r_target;
        w_entry_nxt     = r_entry;
        w_entry_cnt_nxt = r_entry_cnt;
        w_cur_len_nxt   = r_cur_len;
        w_lives_nxt     = r_lives;
        w_score_nxt     = r_score;
        w_timer_nxt     = r_timer;
        w_pass_nxt      = 1'b0;
        w_fail_nxt      = 1'b0;
        w_res_pass_nxt  = r_res_pass;
        case (r_phase)
            PH_IDLE, PH_OVER: begin
                if (start) begin
                    w_cur_len_nxt = START_L;
                    w_lives_nxt   = LIVES_L;
                    w_score_nxt   = '0;
                    w_target_nxt  = mask_digits(rand_val, START_L);
                    w_timer_nxt   = SHOW_T;
                    w_phase_nxt   = PH_SHOW;
                end
            end
            PH_SHOW: begin
                if (tick_en) begin
                    if (r_timer == 8'd1) begin
                        w_entry_nxt     = '0;
                        w_entry_cnt_nxt = '0;
                        w_timer_nxt     = ENTER_T;
                        w_phase_nxt     = PH_ENTER;
                    end else begin
                        w_timer_nxt = r_timer - 8'd1;
                    end
                end
            end
            PH_ENTER: begin
                if (w_key_digit) begin
                    w_entry_nxt     = w_entry_shift;
                    w_entry_cnt_nxt = w_cnt_inc;
                end
                // A completing key outranks a coincident timeout tick.
                if (w_key_digit && (w_cnt_inc == r_cur_len)) begin
                    w_phase_nxt    = PH_RESULT;
                    w_timer_nxt    = RESULT_T;
                    w_res_pass_nxt = (w_entry_shift == r_target);
                    w_pass_nxt     = (w_entry_shift == r_target);
                    w_fail_nxt     = (w_entry_shift != r_target);
                end else if (tick_en) begin
                    if (r_timer == 8'd1) begin
                        w_phase_nxt    = PH_RESULT;
                        w_timer_nxt    = RESULT_T;
                        w_res_pass_nxt = 1'b0;
                        w_fail_nxt     = 1'b1;
                    end else begin
                        w_timer_nxt = r_timer - 8'd1;
                    end
                end
            end
            PH_RESULT: begin
                if (tick_en) begin
                    if (r_timer != 8'd1) begin
                        w_timer_nxt = r_timer - 8'd1;
                    end else if (r_res_pass) begin
                        w_score_nxt   = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
                        w_cur_len_nxt = w_len_up;
                        w_target_nxt  = mask_digits(rand_val, w_len_up);
                        w_timer_nxt   = SHOW_T;
                        w_phase_nxt   = PH_SHOW;
                    end else begin
                        w_lives_nxt = r_lives - 3'd1;
                        if (r_lives == 3'd1) begin
                            w_phase_nxt = PH_OVER;
                        end else begin
                            w_target_nxt = mask_digits(rand_val, r_cur_len);
                            w_timer_nxt  = SHOW_T;
                            w_phase_nxt  = PH_SHOW;
                        end
                    end
                end
            end
            default: w_phase_nxt = PH_IDLE;
        endcase
    end

    assign phase      = r_phase;
    assign target     = r_target;
    assign entry      = r_entry;
    assign entry_cnt  = r_entry_cnt;
    assign cur_len    = r_cur_len;
    assign lives_left = r_lives;
    assign score      = r_score;
    assign pass       = r_pass;
    assign fail       = r_fail;
endmodule

// File: tb/tb_memory_game_ctrl.sv
// tb/tb_memory_game_ctrl.sv - self-checking bench for memory_game_ctrl
module tb_memory_game_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        tick_en = 1'b0;
    logic        start = 1'b0;
    logic [31:0] rand_val = 32'h0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_val = 4'h0;
    logic [2:0]  phase;
    logic [31:0] target;
    logic [31:0] entry;
    logic [3:0]  entry_cnt;
    logic [3:0]  cur_len;
    logic [2:0]  lives_left;
    logic [7:0]  score;
    logic        pass;
    logic        fail;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 0;

    memory_game_ctrl dut (
        .clk(clk), .rst(rst), .tick_en(tick_en), .start(start), .rand_val(rand_val),
        .key_valid(key_valid), .key_val(key_val), .phase(phase), .target(target),
        .entry(entry), .entry_cnt(entry_cnt), .cur_len(cur_len), .lives_left(lives_left),
        .score(score), .pass(pass), .fail(fail)
    );

    always #5 clk = ~clk;

    // Reference model: digits as plain ints, typed entry kept as a list of keys.
    int m_phase, m_timer, m_len, m_lives, m_score;
    int m_tgt[8];
    int ent[$];
    bit m_pass, m_fail, m_respass;

    task automatic latch_target(input int len);
        for (int i = 0; i < 8; i++) m_tgt[i] = (i < len) ? int'((rand_val >> (4*i)) & 32'hF) : 0;
    endtask

    task automatic model_reset();
        m_phase = 0; m_timer = 0; m_len = 4; m_lives = 3; m_score = 0;
        for (int i = 0; i < 8; i++) m_tgt[i] = 0;
        ent.delete();
        m_pass = 0; m_fail = 0; m_respass = 0;
    endtask

    task automatic go_result(input bit ok);
        m_phase = 3; m_timer = 3; m_respass = ok; m_pass = ok; m_fail = !ok;
    endtask

    task automatic model_step();
        bit done;
        bit match;
        done = 0;
        m_pass = 0; m_fail = 0;
        case (m_phase)
            0, 4: if (start) begin
                m_len = 4; m_lives = 3; m_score = 0;
                latch_target(4); m_timer = 6; m_phase = 1;
            end
            1: if (tick_en) begin
                if (m_timer == 1) begin m_phase = 2; ent.delete(); m_timer = 20; end
                else m_timer--;
            end
            2: begin
                if (key_valid && key_val <= 4'd9) begin
                    ent.push_back(int'(key_val));
                    if (ent.size() == m_len) begin
                        match = 1;
                        for (int i = 0; i < m_len; i++) if (ent[m_len-1-i] != m_tgt[i]) match = 0;
                        go_result(match);
                        done = 1;
                    end
                end
                if (!done && tick_en) begin
                    if (m_timer == 1) go_result(0);
                    else m_timer--;
                end
            end
            3: if (tick_en) begin
                if (m_timer != 1) m_timer--;
                else if (m_respass) begin
                    if (m_score < 255) m_score++;
                    if (m_len < 8) m_len++;
                    latch_target(m_len); m_phase = 1; m_timer = 6;
                end else begin
                    m_lives--;
                    if (m_lives == 0) m_phase = 4;
                    else begin latch_target(m_len); m_phase = 1; m_timer = 6; end
                end
            end
            default: ;
        endcase
    endtask

    function automatic logic [31:0] pack_tgt();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[4*i +: 4] = 4'(m_tgt[i]);
        return v;
    endfunction

    function automatic logic [31:0] pack_ent();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < ent.size() && i < 8; i++) v[4*i +: 4] = 4'(ent[ent.size()-1-i]);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) model_reset();
        else model_step();
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("phase", 32'(phase), 32'(m_phase));
            chk("target", target, pack_tgt());
            chk("entry", entry, pack_ent());
            chk("entry_cnt", 32'(entry_cnt), 32'(ent.size()));
            chk("cur_len", 32'(cur_len), 32'(m_len));
            chk("lives_left", 32'(lives_left), 32'(m_lives));
            chk("score", 32'(score), 32'(m_score));
            chk("pass", 32'(pass), 32'(m_pass));
            chk("fail", 32'(fail), 32'(m_fail));
            chk("pass_and_fail", 32'(pass & fail), 32'd0);
        end
    end

    task automatic step(input bit t, input bit kv, input logic [3:0] k, input bit s);
        @(negedge clk);
        tick_en = t; key_valid = kv; key_val = k; start = s;
        @(posedge clk);
        #1;
        tick_en = 0; key_valid = 0; start = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 4'h0, 0);
    endtask

    task automatic key(input logic [3:0] k);
        step(0, 1, k, 0);
    endtask

    task automatic play_pass_round();
        int len;
        ticks(6);
        len = m_len;
        for (int i = len - 1; i >= 0; i--) key(4'(m_tgt[i]));
        chk("round_pass_pulse", 32'(pass), 32'd1);
        ticks(3);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_phase"}, 32'(phase), 32'd0);
        chk({tag, "_target"}, target, 32'd0);
        chk({tag, "_entry"}, entry, 32'd0);
        chk({tag, "_cur_len"}, 32'(cur_len), 32'd4);
        chk({tag, "_lives"}, 32'(lives_left), 32'd3);
        chk({tag, "_score"}, 32'(score), 32'd0);
        chk({tag, "_pass_fail"}, 32'({pass, fail}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        step(0, 0, 4'h0, 0);
        step(0, 0, 4'h0, 0);
        chk_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;
        cmp_en = 1;

        // First round: match the four shown digits.
        rand_val = 32'h9876_5432;
        step(0, 0, 4'h0, 1);
        chk("start_phase", 32'(phase), 32'd1);
        chk("start_target", target, 32'h0000_5432);
        ticks(5);
        chk("show_hold", 32'(phase), 32'd1);
        ticks(1);
        chk("enter_phase", 32'(phase), 32'd2);
        key(4'h5); key(4'h4); key(4'h3);
        chk("entry_partial", entry, 32'h0000_0543);
        key(4'h2);
        chk("pass_pulse", 32'(pass), 32'd1);
        chk("result_phase", 32'(phase), 32'd3);
        step(0, 0, 4'h0, 0);
        chk("pass_one_cycle", 32'(pass), 32'd0);
        rand_val = 32'h1357_2468;
        ticks(3);
        chk("score_after_pass", 32'(score), 32'd1);
        chk("len_after_pass", 32'(cur_len), 32'd5);
        chk("target_len5", target, 32'h0007_2468);

        // Wrong last digit, ignored code 0xB.
        key(4'h3);
        ticks(6);
        key(4'hB);
        chk("key_b_entry", entry, 32'd0);
        chk("key_b_cnt", 32'(entry_cnt), 32'd0);
        key(4'h7); key(4'h2); key(4'h4); key(4'h6); key(4'h9);
        chk("fail_pulse", 32'(fail), 32'd1);
        chk("no_pass_on_fail", 32'(pass), 32'd0);
        rand_val = 32'h1111_2222;
        ticks(3);
        chk("lives_after_fail", 32'(lives_left), 32'd2);
        chk("len_after_fail", 32'(cur_len), 32'd5);
        chk("target_after_fail", target, 32'h0001_2222);

        // Two entry timeouts end the game.
        ticks(6); ticks(19);
        chk("timeout_not_yet", 32'(phase), 32'd2);
        ticks(1);
        chk("timeout_fail", 32'(fail), 32'd1);
        ticks(3);
        chk("lives_1", 32'(lives_left), 32'd1);
        ticks(26);
        ticks(3);
        chk("over_phase", 32'(phase), 32'd4);
        chk("over_lives", 32'(lives_left), 32'd0);
        chk("over_target_held", target, 32'h0001_2222);

        // Restart, then a completing key on the timeout tick.
        rand_val = 32'h0000_4321;
        step(0, 0, 4'h0, 1);
        chk("restart_lives", 32'(lives_left), 32'd3);
        chk("restart_score", 32'(score), 32'd0);
        chk("restart_len", 32'(cur_len), 32'd4);
        chk("restart_target", target, 32'h0000_4321);
        step(0, 0, 4'h0, 1);
        ticks(6);
        ticks(19);
        key(4'h4); key(4'h3); key(4'h2);
        step(1, 1, 4'h1, 0);
        chk("coincident_pass", 32'(pass), 32'd1);
        chk("coincident_no_fail", 32'(fail), 32'd0);
        rand_val = 32'h8765_4321;
        ticks(3);

        // Climb to the widest target and past it.
        for (int r = 0; r < 4; r++) play_pass_round();
        chk("len_capped", 32'(cur_len), 32'd8);
        chk("score_5", 32'(score), 32'd5);
        chk("target_len8", target, 32'h8765_4321);
        play_pass_round();
        chk("len_stays_8", 32'(cur_len), 32'd8);
        chk("score_6", 32'(score), 32'd6);

        // Reset in the middle of SHOW.
        ticks(2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_values("mid_rst");
        step(0, 0, 4'h0, 0);
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 4'h0, 0);

        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
